// File: rtl/bsr_meta_pkg.sv
// Shared definitions for the BSR metadata server: FSM states, the col_idx table base
// and cache geometry helpers (bsr_scheduler uses the same COL_BASE).
package bsr_meta_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_MISS_REQ,
      ST_MISS_WAIT,
      ST_RESP
   } meta_state_t;

   localparam int COL_BASE_DEF = 128;

   function automatic int idx_w(input int cache_depth);
      return $clog2(cache_depth);
   endfunction

   function automatic int tag_w(input int meta_depth, input int cache_depth);
      return $clog2(meta_depth) - $clog2(cache_depth);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/meta_tag_store.sv
// Direct-mapped one-word-per-line cache storage: combinational read, synchronous fill,
// and a flush that drops every valid bit.
module meta_tag_store #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic [IDX_W-1:0]  i_idx,
   output logic              o_rd_valid,
   output logic [TAG_W-1:0]  o_rd_tag,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_wr_en,
   input  logic [TAG_W-1:0]  i_wr_tag,
   input  logic [DATA_W-1:0] i_wr_data
);

   logic [DEPTH-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];

   assign o_rd_valid = r_valid[i_idx];
   assign o_rd_tag   = r_tag[i_idx];
   assign o_rd_data  = r_data[i_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
      end else begin
         // flush wins over a coincident fill so the line stays invalid
         if (i_flush)
            r_valid <= '0;
         else if (i_wr_en)
            r_valid[i_idx] <= 1'b1;
         if (i_wr_en) begin
            r_tag[i_idx]  <= i_wr_tag;
            r_data[i_idx] <= i_wr_data;
         end
      end
   end

endmodule

// File: rtl/bsr_meta_decode.sv
// Metadata server between the BSR metadata BRAM and bsr_scheduler: cached single-word
// reads, variable-latency miss fetch, sticky bounds errors and hit/miss statistics.
//
// state        | meaning
// ST_IDLE      | waiting for meta_ren, latches request address
// ST_LOOKUP    | range check and cache tag compare
// ST_MISS_REQ  | mem_req held until mem_gnt
// ST_MISS_WAIT | waiting for the mem_rvalid pulse, fills the line
// ST_RESP      | meta_rvalid held until meta_ready, col_idx bound check
module bsr_meta_decode
   import bsr_meta_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int META_DEPTH  = 1024,
   parameter int COL_BASE    = COL_BASE_DEF,
   parameter int CACHE_DEPTH = 16,
   parameter int N_W         = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [N_W-1:0]                NT,
   input  logic                          meta_ren,
   input  logic [31:0]                   meta_raddr,
   output logic [DATA_W-1:0]             meta_rdata,
   output logic                          meta_rvalid,
   input  logic                          meta_ready,
   output logic                          mem_req,
   output logic [$clog2(META_DEPTH)-1:0] mem_addr,
   input  logic                          mem_gnt,
   input  logic                          mem_rvalid,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic                          busy,
   output logic                          err_col,
   output logic                          err_addr,
   output logic [31:0]                   hit_cnt,
   output logic [31:0]                   miss_cnt
);

   localparam int AW    = $clog2(META_DEPTH);
   localparam int IDX_W = idx_w(CACHE_DEPTH);
   localparam int TAG_W = tag_w(META_DEPTH, CACHE_DEPTH);

   meta_state_t       r_state;
   logic [31:0]       r_req_addr;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic              r_mem_req;
   logic              r_fill_kill;
   logic              r_err_col;
   logic              r_err_addr;
   logic [31:0]       r_hit_cnt;
   logic [31:0]       r_miss_cnt;

   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic              w_line_valid;
   logic [TAG_W-1:0]  w_line_tag;
   logic [DATA_W-1:0] w_line_data;
   logic              w_in_range;
   logic              w_hit;
   logic              w_fill;
   logic [DATA_W-1:0] w_nt_ext;

   assign w_idx      = r_req_addr[IDX_W-1:0];
   assign w_tag      = r_req_addr[AW-1:IDX_W];
   assign w_in_range = r_req_addr < 32'(META_DEPTH);
   assign w_hit      = w_line_valid && (w_line_tag == w_tag);
   assign w_nt_ext   = {{(DATA_W-N_W){1'b0}}, NT};
   // a flush anywhere in the miss window means the fetched word may belong to the old layer
   assign w_fill     = (r_state == ST_MISS_WAIT) && mem_rvalid && !r_fill_kill && !flush;

   meta_tag_store #(
      .DEPTH  (CACHE_DEPTH),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) u_tag_store (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (flush),
      .i_idx      (w_idx),
      .o_rd_valid (w_line_valid),
      .o_rd_tag   (w_line_tag),
      .o_rd_data  (w_line_data),
      .i_wr_en    (w_fill),
      .i_wr_tag   (w_tag),
      .i_wr_data  (mem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_req_addr  <= '0;
         r_rdata     <= '0;
         r_rvalid    <= 1'b0;
         r_mem_req   <= 1'b0;
         r_fill_kill <= 1'b0;
         r_err_col   <= 1'b0;
         r_err_addr  <= 1'b0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (meta_ren) begin
                  r_req_addr <= meta_raddr;
                  r_state    <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (!w_in_range) begin
                  r_rdata    <= '0;
                  r_err_addr <= 1'b1;
                  r_rvalid   <= 1'b1;
                  r_state    <= ST_RESP;
               end else if (w_hit) begin
                  r_rdata   <= w_line_data;
                  r_hit_cnt <= sat_inc(r_hit_cnt);
                  r_rvalid  <= 1'b1;
                  r_state   <= ST_RESP;
               end else begin
                  r_miss_cnt  <= sat_inc(r_miss_cnt);
                  r_mem_req   <= 1'b1;
                  r_fill_kill <= 1'b0;
                  r_state     <= ST_MISS_REQ;
               end
            end
            ST_MISS_REQ: begin
               if (flush)
                  r_fill_kill <= 1'b1;
               if (mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_MISS_WAIT;
               end
            end
            ST_MISS_WAIT: begin
               if (flush)
                  r_fill_kill <= 1'b1;
               if (mem_rvalid) begin
                  r_rdata  <= mem_rdata;
                  r_rvalid <= 1'b1;
                  r_state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               if ((r_req_addr >= 32'(COL_BASE)) && (r_rdata >= w_nt_ext))
                  r_err_col <= 1'b1;
               if (meta_ready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign meta_rdata  = r_rdata;
   assign meta_rvalid = r_rvalid;
   assign mem_req     = r_mem_req;
   assign mem_addr    = r_req_addr[AW-1:0];
   assign busy        = (r_state != ST_IDLE);
   assign err_col     = r_err_col;
   assign err_addr    = r_err_addr;
   assign hit_cnt     = r_hit_cnt;
   assign miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_bsr_meta_decode.sv
// Directed bench for bsr_meta_decode: cold miss, warm hit, conflict eviction, bounds
// errors, flush during a miss and reset during a miss, against a small BRAM responder.
module tb_bsr_meta_decode;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [9:0]  NT;
   logic        meta_ren;
   logic [31:0] meta_raddr;
   logic [31:0] meta_rdata;
   logic        meta_rvalid;
   logic        meta_ready;
   logic        mem_req;
   logic [9:0]  mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        err_col;
   logic        err_addr;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] tb_mem [1024];
   int          lat       = 4;
   int          req_count = 0;
   logic [9:0]  last_addr = '0;
   bit          bram_en   = 1;
   bit          force_rv  = 0;
   logic [31:0] force_dat = '0;

   bsr_meta_decode dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .NT          (NT),
      .meta_ren    (meta_ren),
      .meta_raddr  (meta_raddr),
      .meta_rdata  (meta_rdata),
      .meta_rvalid (meta_rvalid),
      .meta_ready  (meta_ready),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .err_col     (err_col),
      .err_addr    (err_addr),
      .hit_cnt     (hit_cnt),
      .miss_cnt    (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // BRAM model: grants in the cycle mem_req is seen, returns data lat cycles later
   initial begin
      bit         pend;
      int         cnt;
      logic [9:0] paddr;
      pend = 0;
      cnt  = 0;
      paddr = '0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_gnt    = 1'b0;
         mem_rvalid = force_rv;
         if (force_rv) mem_rdata = force_dat;
         if (rst) begin
            pend = 0;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = tb_mem[paddr];
               pend = 0;
            end
         end else if (mem_req && bram_en) begin
            mem_gnt   = 1'b1;
            pend      = 1;
            cnt       = lat;
            paddr     = mem_addr;
            last_addr = mem_addr;
            req_count++;
         end
      end
   end

   task automatic do_read(input string tag, input logic [31:0] a,
                          output logic [31:0] d, output int cyc);
      @(negedge clk);
      meta_ren   = 1'b1;
      meta_raddr = a;
      @(negedge clk);
      meta_ren = 1'b0;
      cyc = 1;
      while (!meta_rvalid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_no_timeout"}, 32'(cyc < 100), 32'd1);
      d = meta_rdata;
      @(negedge clk);
      chk({tag, "_rdata_hold"}, meta_rdata, d);
      meta_ready = 1'b1;
      @(negedge clk);
      meta_ready = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int          cyc;
      int          rc;

      foreach (tb_mem[i]) tb_mem[i] = 32'h0;
      tb_mem[3]   = 32'h0000_0005;
      tb_mem[19]  = 32'h0000_0013;
      tb_mem[5]   = 32'h0000_0055;
      tb_mem[130] = 32'h0000_0009;
      tb_mem[131] = 32'h0000_0007;

      rst = 1'b1; flush = 1'b0; NT = 10'd8;
      meta_ren = 1'b0; meta_raddr = '0; meta_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rvalid",  32'(meta_rvalid), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_busy",    32'(busy), 32'd0);
      chk("rst_errs",    {30'd0, err_col, err_addr}, 32'd0);
      chk("rst_hit",     hit_cnt, 32'd0);
      chk("rst_miss",    miss_cnt, 32'd0);
      chk("rst_rdata",   meta_rdata, 32'd0);
      rst = 1'b0;

      // cold miss
      pulse_flush();
      do_read("cold", 32'd3, d, cyc);
      chk("cold_data", d, 32'd5);
      chk("cold_lat", 32'(cyc), 32'd7);
      chk("cold_reqs", 32'(req_count), 32'd1);
      chk("cold_addr", 32'(last_addr), 32'd3);
      chk("cold_miss", miss_cnt, 32'd1);

      // warm hit
      do_read("warm", 32'd3, d, cyc);
      chk("warm_data", d, 32'd5);
      chk("warm_lat", 32'(cyc), 32'd2);
      chk("warm_reqs", 32'(req_count), 32'd1);
      chk("warm_hit", hit_cnt, 32'd1);

      // conflict eviction: 3 and 19 share index 3
      pulse_flush();
      do_read("conf_a", 32'd3, d, cyc);
      chk("conf_a_data", d, 32'd5);
      do_read("conf_b", 32'd19, d, cyc);
      chk("conf_b_data", d, 32'h13);
      do_read("conf_c", 32'd3, d, cyc);
      chk("conf_c_data", d, 32'd5);
      chk("conf_miss", miss_cnt, 32'd4);
      chk("conf_reqs", 32'(req_count), 32'd4);
      chk("conf_hit", hit_cnt, 32'd1);

      // column bound
      chk("col_pre", 32'(err_col), 32'd0);
      do_read("col_a", 32'd130, d, cyc);
      chk("col_a_data", d, 32'd9);
      chk("col_a_err", 32'(err_col), 32'd1);
      do_read("col_b", 32'd131, d, cyc);
      chk("col_b_data", d, 32'd7);
      chk("col_b_err", 32'(err_col), 32'd1);

      // address bound
      chk("addr_pre", 32'(err_addr), 32'd0);
      rc = req_count;
      do_read("oob", 32'd2000, d, cyc);
      chk("oob_data", d, 32'd0);
      chk("oob_lat", 32'(cyc), 32'd2);
      chk("oob_err", 32'(err_addr), 32'd1);
      chk("oob_reqs", 32'(req_count), 32'(rc));

      // flush during MISS_WAIT: response still returned, fill suppressed
      rc = req_count;
      fork
         do_read("fl_a", 32'd5, d, cyc);
         begin
            repeat (4) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
         end
      join
      chk("fl_a_data", d, 32'h55);
      do_read("fl_b", 32'd5, d, cyc);
      chk("fl_b_data", d, 32'h55);
      chk("fl_reqs", 32'(req_count), 32'(rc + 2));

      // reset during MISS_REQ, then a late mem_rvalid
      bram_en = 0;
      @(negedge clk);
      meta_ren = 1'b1;
      meta_raddr = 32'd7;
      @(negedge clk);
      meta_ren = 1'b0;
      @(negedge clk);
      chk("mr_req_up", 32'(mem_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("mr_req_down", 32'(mem_req), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      force_rv = 1; force_dat = 32'hAB;
      @(negedge clk);
      force_rv = 0;
      @(negedge clk);
      chk("late_rvalid", 32'(meta_rvalid), 32'd0);
      chk("late_busy", 32'(busy), 32'd0);
      chk("late_rdata", meta_rdata, 32'd0);
      chk("late_errs", {30'd0, err_col, err_addr}, 32'd0);
      bram_en = 1;
      rc = req_count;
      do_read("post", 32'd3, d, cyc);
      chk("post_data", d, 32'd5);
      chk("post_miss", miss_cnt, 32'd1);
      chk("post_reqs", 32'(req_count), 32'(rc + 1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
